cursor_ctrl: RTL and testbench
==============================

// Module: cursor_ctrl
// PURPOSE
// Turns player buttons into the cursor position and ship orientation that the cursor
// renderer and the board logic consume. Inputs are synchronised, debounced and edge-detected.
// Held direction buttons auto-repeat. The cursor is kept on-grid for the current ship
// length and orientation. Select issues a place/fire command using a valid/ready handshake.
// The block sits between the board button inputs and the game FSM / cursor renderer.
// PARAMETERS
// GRID_SIZE        10        cells per row/column; legal coordinates are 0..GRID_SIZE-1
// DEBOUNCE_CYCLES  500000    cycles a synchronised input must be stable before accepted
// REPEAT_DELAY     25000000  cycles a direction is held before the first auto-repeat
// REPEAT_RATE      6250000   cycles between later auto-repeats while still held
// PORTS
// clk                  in   1   system clock
// reset                in   1   asynchronous, active-high reset
// btn_up/down/left/right in 1   raw direction buttons, active-high, asynchronous to clk
// btn_rotate           in   1   raw rotate button, active-high
// btn_select           in   1   raw select button, active-high
// game_state           in   game_state_t  current game phase
// current_ship_length  in   4   length of the ship being placed (placement phase only)
// cmd_ready            in   1   game FSM accepts the command
// cursor_x             out  4   cursor column, 0..GRID_SIZE-1
// cursor_y             out  4   cursor row, 0..GRID_SIZE-1
// orientation          out  1   0 = horizontal, 1 = vertical
// cmd_valid            out  1   place/fire command pending
// cmd_place            out  1   1 = place at cursor/orientation, 0 = fire at cursor; stable while cmd_valid
// BEHAVIOUR
// - Reset (async, active-high): cursor_x=0, cursor_y=0, orientation=0, cmd_valid=0, cmd_place=0.
//   All synchronisers, debounce counters and repeat counters clear.
// - Input conditioning, per button:
//   - 2-flop synchroniser, then a debounce counter.
//   - The debounced level changes only after DEBOUNCE_CYCLES consecutive equal synced samples.
//   - A press event is the 0->1 edge of the debounced level.
// - Auto-repeat (directions only):
//   - While the debounced level stays 1, the first extra event fires REPEAT_DELAY cycles after the press.
//   - After that, one event fires every REPEAT_RATE cycles.
//   - Release clears the counter.
// - Latency: a press event updates the outputs on the next rising clk edge.
// - Limits:
//   - len = max(current_ship_length, 1), saturated to GRID_SIZE.
//   - Placement phase, horizontal: max_x = GRID_SIZE-len, max_y = GRID_SIZE-1.
//   - Placement phase, vertical: max_x = GRID_SIZE-1, max_y = GRID_SIZE-len.
//   - Other phases: max_x = max_y = GRID_SIZE-1, and orientation is held (rotate is ignored).
// - Movement: up decrements y, down increments y, left decrements x, right increments x.
//   - Without the macro, moves saturate at 0 and at max.
//   - up+down in the same cycle cancel; left+right in the same cycle cancel.
//   - A vertical and a horizontal event in the same cycle both apply.
// - Rotate (placement phase only): orientation toggles. In the same cycle, x and y are
//   clamped to the new limits (e.g. x=8, len=3, going 1->0 gives x=7).
// - Continuous clamp: every cycle, a coordinate above its current limit is forced to the
//   limit. This covers length changes and phase changes.
// - Per-cycle priority:
//   - cmd_valid=1: direction, rotate and select events are discarded; only the clamp acts.
//   - select event: cmd_valid<=1 and cmd_place<=(game_state==PLACEMENT_PHASE).
//     Moves and rotates in that same cycle are discarded.
//   - Otherwise, rotate is applied, then moves are applied against the post-rotate limits.
// - Handshake: the command completes on a clk edge with cmd_valid && cmd_ready, and
//   cmd_valid<=0 on that edge. cmd_ready while idle has no effect.
//   cursor_x/y, orientation and cmd_place are frozen while cmd_valid=1.
// - Reset during a pending command drops it (cmd_valid=0). No other cancel path exists.
// - Arithmetic is done in 5 bits so 0-1 and max+1 are detected with no 4-bit wrap.
// CONFIGURATION
// - CURSOR_WRAP_EN defined: a move below 0 goes to max and a move above max goes to 0,
//   on that axis's current limit. Rotate and continuous clamp still saturate.
// - CURSOR_WRAP_EN undefined: saturating moves, as described above.
// TESTING
// Bench parameters: GRID_SIZE=10, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.
// 1. Reset, then one 10-cycle right pulse: x=1, exactly 2+4+1 cycles after the rising edge.
//    A 3-cycle glitch on right gives no change.
// 2. Placement phase, len=4, horizontal, right held 200 cycles: x steps to 6 and stays there.
//    With CURSOR_WRAP_EN, x goes 6->0 on the next repeat.
// 3. x=0, y=8, len=3, rotate to vertical: orientation=1 and y=7 in the same cycle.
//    Rotate again: orientation=0, y=7.
// 4. Select in placement phase with cmd_ready=0: cmd_valid=1, cmd_place=1; presses for
//    50 cycles leave x/y unchanged. cmd_ready=1 for one cycle: cmd_valid=0 on the next edge.
// 5. game_state not PLACEMENT_PHASE, x=9: rotate gives no change; select gives cmd_place=0.
//    Up+down together: y unchanged.
// 6. cmd_valid=1, then reset asserted mid-cycle: all outputs 0 immediately, with no clock edge.

Source files
------------

// File: rtl/cursor_ctrl_if.sv
// Command handshake bundle for cursor_ctrl, plus the shared game-phase type.
// master: cmd_valid/cmd_place out, cmd_ready in. slave: the reverse.
package cursor_pkg;
  typedef enum logic [1:0] {
    IDLE_PHASE,
    PLACEMENT_PHASE,
    FIRE_PHASE,
    OVER_PHASE
  } game_state_t;
endpackage

interface cursor_ctrl_if;
  logic cmd_valid;
  logic cmd_place;
  logic cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_place,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_place,
    output cmd_ready
  );
endinterface

// File: rtl/cursor_ctrl.sv
// Cursor/orientation control from debounced, auto-repeating buttons; place/fire cmd.
// Ports: clk, reset (async high), btn_*, game_state, current_ship_length,
// cursor_x/y, orientation, cmd (cursor_ctrl_if.master). Option: CURSOR_WRAP_EN.
module cursor_ctrl
  import cursor_pkg::*;
#(
  parameter int GRID_SIZE       = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 6250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_rotate,
  input  logic        btn_select,
  input  game_state_t game_state,
  input  logic [3:0]  current_ship_length,
  output logic [3:0]  cursor_x,
  output logic [3:0]  cursor_y,
  output logic        orientation,
  cursor_ctrl_if.master cmd
);

  localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]     G5      = 5'(GRID_SIZE);

  // bit order: 0 up, 1 down, 2 left, 3 right, 4 rotate, 5 select
  logic [5:0]     raw;
  logic [5:0]     s1;
  logic [5:0]     s2;
  logic [5:0]     lvl;
  logic [5:0]     lvl_d;
  logic [DBW-1:0] db_cnt [6];
  logic [RW-1:0]  rp_cnt [4];
  logic [3:0]     rp_fast;
  logic [3:0]     rp_hit;
  logic [5:0]     evt;

  assign raw = {btn_select, btn_rotate, btn_right,
                btn_left, btn_down, btn_up};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      lvl   <= '0;
      lvl_d <= '0;
      for (int i = 0; i < 6; i++) db_cnt[i] <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      lvl_d <= lvl;
      for (int i = 0; i < 6; i++) begin
        if (s2[i] == lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          lvl[i]    <= s2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // rp_cnt counts cycles since the press (or since the last repeat)
  always_comb begin
    rp_hit = '0;
    for (int i = 0; i < 4; i++) begin
      rp_hit[i] = lvl[i] &&
        (rp_cnt[i] == (rp_fast[i] ? RW'(REPEAT_RATE)
                                  : RW'(REPEAT_DELAY)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rp_fast <= '0;
      for (int i = 0; i < 4; i++) rp_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!lvl[i]) begin
          rp_cnt[i]  <= '0;
          rp_fast[i] <= 1'b0;
        end else if (rp_hit[i]) begin
          rp_cnt[i]  <= RW'(1);
          rp_fast[i] <= 1'b1;
        end else begin
          rp_cnt[i]  <= rp_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign evt = (lvl & ~lvl_d) | {2'b00, rp_hit};

  typedef enum logic {
    CMD_IDLE,
    CMD_PEND
  } cmd_state_t;

  cmd_state_t st_q;
  cmd_state_t st_d;

  logic sel_evt;
  logic act;
  logic placement;

  assign sel_evt   = evt[5];
  assign placement = (game_state == PLACEMENT_PHASE);
  assign act       = (st_q == CMD_IDLE) && !sel_evt;

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      CMD_IDLE: if (sel_evt)       st_d = CMD_PEND;
      CMD_PEND: if (cmd.cmd_ready) st_d = CMD_IDLE;
      default:                     st_d = CMD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q          <= CMD_IDLE;
      cmd.cmd_place <= 1'b0;
    end else begin
      st_q <= st_d;
      if (st_q == CMD_IDLE && sel_evt)
        cmd.cmd_place <= placement;
    end
  end

  assign cmd.cmd_valid = (st_q == CMD_PEND);

  function automatic logic [4:0] step(
    input logic [4:0] v,
    input logic [4:0] m,
    input logic       inc,
    input logic       dec
  );
    logic [4:0] r;
    r = v;
    if (inc && !dec) begin
      r = v + 5'd1;
`ifdef CURSOR_WRAP_EN
      if (r > m) r = '0;
`else
      if (r > m) r = m;
`endif
    end else if (dec && !inc) begin
      r = v - 5'd1;
      // v <= 15, so 0-1 is the only case that sets bit 4
`ifdef CURSOR_WRAP_EN
      if (r[4]) r = m;
`else
      if (r[4]) r = '0;
`endif
    end
    return r;
  endfunction

  logic       orient_n;
  logic [4:0] len;
  logic [4:0] max_x;
  logic [4:0] max_y;
  logic [4:0] xc;
  logic [4:0] yc;
  logic [4:0] xm;
  logic [4:0] ym;

  always_comb begin
    len = {1'b0, current_ship_length};
    if (len == 5'd0) len = 5'd1;
    if (len > G5)    len = G5;

    orient_n = orientation;
    if (act && evt[4] && placement) orient_n = ~orientation;

    max_x = G5 - 5'd1;
    max_y = G5 - 5'd1;
    if (placement) begin
      if (orient_n) max_y = G5 - len;
      else          max_x = G5 - len;
    end

    // clamp first: covers rotate, length and phase changes
    xc = {1'b0, cursor_x};
    yc = {1'b0, cursor_y};
    if (xc > max_x) xc = max_x;
    if (yc > max_y) yc = max_y;

    xm = step(xc, max_x, act && evt[3], act && evt[2]);
    ym = step(yc, max_y, act && evt[1], act && evt[0]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cursor_x    <= '0;
      cursor_y    <= '0;
      orientation <= 1'b0;
    end else begin
      cursor_x    <= xm[3:0];
      cursor_y    <= ym[3:0];
      orientation <= orient_n;
    end
  end

endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed bench for cursor_ctrl: debounce latency, repeat, limits,
// rotate clamp, command handshake and async reset.
module tb_cursor_ctrl;
  import cursor_pkg::*;

  logic        clk;
  logic        reset;
  logic [5:0]  btns;
  game_state_t game_state;
  logic [3:0]  ship_len;
  logic [3:0]  cursor_x;
  logic [3:0]  cursor_y;
  logic        orientation;
  int          checks;
  int          errors;

  cursor_ctrl_if cmd_if();

  cursor_ctrl #(
    .GRID_SIZE      (10),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_RATE    (8)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .btn_up             (btns[0]),
    .btn_down           (btns[1]),
    .btn_left           (btns[2]),
    .btn_right          (btns[3]),
    .btn_rotate         (btns[4]),
    .btn_select         (btns[5]),
    .game_state         (game_state),
    .current_ship_length(ship_len),
    .cursor_x           (cursor_x),
    .cursor_y           (cursor_y),
    .orientation        (orientation),
    .cmd                (cmd_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tap(input int b);
    @(negedge clk);
    btns[b] = 1'b1;
    repeat (10) @(negedge clk);
    btns[b] = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset;
    checks++;
    if (cursor_x !== 4'd0) begin
      errors++; $display("FAIL reset_x: got %0d want 0", cursor_x);
    end
    checks++;
    if (cursor_y !== 4'd0) begin
      errors++; $display("FAIL reset_y: got %0d want 0", cursor_y);
    end
    checks++;
    if (orientation !== 1'b0) begin
      errors++; $display("FAIL reset_or: got %0b want 0", orientation);
    end
    checks++;
    if (cmd_if.cmd_valid !== 1'b0 || cmd_if.cmd_place !== 1'b0) begin
      errors++;
      $display("FAIL reset_cmd: got v=%0b p=%0b want 0 0",
               cmd_if.cmd_valid, cmd_if.cmd_place);
    end
  endtask

  task automatic test_latency;
    @(negedge clk);
    btns[3] = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (cursor_x !== 4'd0) begin
      errors++; $display("FAIL lat_early: got %0d want 0", cursor_x);
    end
    @(negedge clk);
    checks++;
    if (cursor_x !== 4'd1) begin
      errors++; $display("FAIL lat_edge7: got %0d want 1", cursor_x);
    end
    repeat (3) @(negedge clk);
    btns[3] = 1'b0;
    repeat (12) @(negedge clk);
    btns[3] = 1'b1;
    repeat (3) @(negedge clk);
    btns[3] = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (cursor_x !== 4'd1) begin
      errors++; $display("FAIL glitch: got %0d want 1", cursor_x);
    end
  endtask

  task automatic test_repeat;
    @(negedge clk);
    btns[3] = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (cursor_x !== 4'd3) begin
      errors++; $display("FAIL rep_first: got %0d want 3", cursor_x);
    end
    repeat (170) @(negedge clk);
    checks++;
    if (cursor_x !== 4'd6) begin
      errors++; $display("FAIL rep_sat: got %0d want 6", cursor_x);
    end
    btns[3] = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_left_floor;
    for (int i = 0; i < 7; i++) tap(2);
    checks++;
    if (cursor_x !== 4'd0) begin
      errors++; $display("FAIL left_floor: got %0d want 0", cursor_x);
    end
  endtask

  task automatic test_rotate;
    ship_len = 4'd3;
    for (int i = 0; i < 8; i++) tap(1);
    checks++;
    if (cursor_y !== 4'd8) begin
      errors++; $display("FAIL down8: got %0d want 8", cursor_y);
    end
    @(negedge clk);
    btns[4] = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (orientation !== 1'b0 || cursor_y !== 4'd8) begin
      errors++;
      $display("FAIL rot_pre: got o=%0b y=%0d want 0 8",
               orientation, cursor_y);
    end
    @(negedge clk);
    checks++;
    if (orientation !== 1'b1 || cursor_y !== 4'd7) begin
      errors++;
      $display("FAIL rot_vert: got o=%0b y=%0d want 1 7",
               orientation, cursor_y);
    end
    repeat (3) @(negedge clk);
    btns[4] = 1'b0;
    repeat (12) @(negedge clk);
    tap(4);
    checks++;
    if (orientation !== 1'b0 || cursor_y !== 4'd7) begin
      errors++;
      $display("FAIL rot_back: got o=%0b y=%0d want 0 7",
               orientation, cursor_y);
    end
  endtask

  task automatic test_cmd_hold;
    tap(5);
    checks++;
    if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_place !== 1'b1) begin
      errors++;
      $display("FAIL sel_place: got v=%0b p=%0b want 1 1",
               cmd_if.cmd_valid, cmd_if.cmd_place);
    end
    @(negedge clk);
    btns[3] = 1'b1;
    btns[1] = 1'b1;
    btns[4] = 1'b1;
    repeat (50) @(negedge clk);
    btns = '0;
    repeat (12) @(negedge clk);
    checks++;
    if (cursor_x !== 4'd0 || cursor_y !== 4'd7 ||
        orientation !== 1'b0) begin
      errors++;
      $display("FAIL frozen: got x=%0d y=%0d o=%0b want 0 7 0",
               cursor_x, cursor_y, orientation);
    end
    checks++;
    if (cmd_if.cmd_valid !== 1'b1) begin
      errors++; $display("FAIL pend: got %0b want 1", cmd_if.cmd_valid);
    end
    cmd_if.cmd_ready = 1'b1;
    @(negedge clk);
    cmd_if.cmd_ready = 1'b0;
    checks++;
    if (cmd_if.cmd_valid !== 1'b0) begin
      errors++; $display("FAIL done: got %0b want 0", cmd_if.cmd_valid);
    end
    cmd_if.cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    cmd_if.cmd_ready = 1'b0;
    checks++;
    if (cmd_if.cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready: got %0b want 0", cmd_if.cmd_valid);
    end
  endtask

  task automatic test_other_phase;
    game_state = FIRE_PHASE;
    for (int i = 0; i < 10; i++) tap(3);
    checks++;
    if (cursor_x !== 4'd9) begin
      errors++; $display("FAIL x_max: got %0d want 9", cursor_x);
    end
    tap(4);
    checks++;
    if (orientation !== 1'b0 || cursor_x !== 4'd9) begin
      errors++;
      $display("FAIL rot_ign: got o=%0b x=%0d want 0 9",
               orientation, cursor_x);
    end
    tap(5);
    checks++;
    if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_place !== 1'b0) begin
      errors++;
      $display("FAIL sel_fire: got v=%0b p=%0b want 1 0",
               cmd_if.cmd_valid, cmd_if.cmd_place);
    end
    cmd_if.cmd_ready = 1'b1;
    @(negedge clk);
    cmd_if.cmd_ready = 1'b0;
    @(negedge clk);
    btns[0] = 1'b1;
    btns[1] = 1'b1;
    repeat (10) @(negedge clk);
    btns = '0;
    repeat (12) @(negedge clk);
    checks++;
    if (cursor_y !== 4'd7) begin
      errors++; $display("FAIL updown: got %0d want 7", cursor_y);
    end
    game_state = PLACEMENT_PHASE;
    @(negedge clk);
    checks++;
    if (cursor_x !== 4'd7) begin
      errors++; $display("FAIL clamp_phase: got %0d want 7", cursor_x);
    end
  endtask

  task automatic test_async_reset;
    tap(5);
    checks++;
    if (cmd_if.cmd_valid !== 1'b1) begin
      errors++; $display("FAIL pre_rst: got %0b want 1", cmd_if.cmd_valid);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (cursor_x !== 4'd0 || cursor_y !== 4'd0 || orientation !== 1'b0 ||
        cmd_if.cmd_valid !== 1'b0 || cmd_if.cmd_place !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: got x=%0d y=%0d o=%0b v=%0b p=%0b want 0s",
               cursor_x, cursor_y, orientation,
               cmd_if.cmd_valid, cmd_if.cmd_place);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    btns = '0;
    game_state = PLACEMENT_PHASE;
    ship_len = 4'd4;
    cmd_if.cmd_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    reset = 1'b0;
    test_latency;
    test_repeat;
    test_left_floor;
    test_rotate;
    test_cmd_hold;
    test_other_phase;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
